// File: rtl/seq_det_pkg.sv
// Shared encodings and defaults for the serial 1101 pattern detector.
package seq_det_pkg;

  localparam int STATE_W   = 3;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

endpackage

// File: rtl/det_counter.sv
// Wrap-around detection counter with a sticky overflow flag.
module det_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             CLR,
  input  logic             inc,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] Count,
  output logic             Ovf
);

  // A clear on the same edge as an increment wins, so that detection is dropped.
  always_ff @(posedge Clk or posedge CLR) begin
    if (CLR) begin
      Count <= '0;
      Ovf   <= 1'b0;
    end else if (CNT_CLR) begin
      Count <= '0;
      Ovf   <= 1'b0;
    end else if (inc) begin
      Count <= Count + CNT_W'(1);
      if (Count == '1) begin
        Ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq1101_detector.sv
// Moore FSM recognising overlapping 1101 on a qualified serial stream,
// with a detection counter driven from the next-state compare.
module seq1101_detector
  import seq_det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             CLR,
  input  logic             EN,
  input  logic             Din,
  input  logic             CNT_CLR,
  output logic             Det,
  output logic [CNT_W-1:0] Count,
  output logic             Ovf
);

  state_t state_q;
  state_t state_d;
  logic   inc;

  always_ff @(posedge Clk or posedge CLR) begin
    if (CLR) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // With EN low the state holds, so a stall is invisible to the matcher.
  always_comb begin
    state_d = state_q;
    if (EN) begin
      unique case (state_q)
        S0:      state_d = Din ? S1 : S0;
        S1:      state_d = Din ? S2 : S0;
        S2:      state_d = Din ? S2 : S3;
        S3:      state_d = Din ? S4 : S0;
        S4:      state_d = Din ? S2 : S0;
        default: state_d = S0;
      endcase
    end
  end

  // Gating with EN keeps a stall in S4 from counting the same match twice.
  assign inc = EN && (state_d == S4);
  assign Det = (state_q == S4);

  det_counter #(
    .CNT_W(CNT_W)
  ) u_det_counter (
    .Clk    (Clk),
    .CLR    (CLR),
    .inc    (inc),
    .CNT_CLR(CNT_CLR),
    .Count  (Count),
    .Ovf    (Ovf)
  );

endmodule

// File: tb/tb_seq1101_detector.sv
// Scoreboard bench for seq1101_detector: stimulus queues expected outputs,
// a monitor pops and compares them after each edge or asynchronous probe.
module tb_seq1101_detector;

  logic       Clk;
  logic       CLR;
  logic       EN;
  logic       Din;
  logic       CNT_CLR;
  logic       Det;
  logic [3:0] Count;
  logic       Ovf;
  logic       probe;

  int checkCount;
  int passCount;

  typedef struct {
    logic       det;
    logic [3:0] cnt;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t expQ[$];

  seq1101_detector #(
    .CNT_W(4)
  ) dut (
    .Clk    (Clk),
    .CLR    (CLR),
    .EN     (EN),
    .Din    (Din),
    .CNT_CLR(CNT_CLR),
    .Det    (Det),
    .Count  (Count),
    .Ovf    (Ovf)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input exp_t e);
    checkCount++;
    if (Det === e.det && Count === e.cnt && Ovf === e.ovf) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got Det=%b Count=%0d Ovf=%b, expected Det=%b Count=%0d Ovf=%b",
               e.name, Det, Count, Ovf, e.det, e.cnt, e.ovf);
    end
  endtask

  // Monitor: the DUT presents new outputs after each edge or async clear.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk or posedge probe);
      #1;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic pushExp(input logic det, input logic [3:0] cnt, input logic ovf,
                         input string name);
    exp_t e;
    e.det  = det;
    e.cnt  = cnt;
    e.ovf  = ovf;
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic en, input logic din, input logic cc,
                               input logic expDet, input logic [3:0] expCnt,
                               input logic expOvf, input string name);
    @(negedge Clk);
    EN      = en;
    Din     = din;
    CNT_CLR = cc;
    pushExp(expDet, expCnt, expOvf, name);
  endtask

  // Raises CLR between edges; outputs must clear before the next edge.
  task automatic asyncClear(input string name);
    @(negedge Clk);
    #1;
    CLR     = 1'b1;
    EN      = 1'b0;
    CNT_CLR = 1'b0;
    pushExp(1'b0, 4'd0, 1'b0, name);
    probe = 1'b1;
    #2;
    probe = 1'b0;
    CLR   = 1'b0;
    pushExp(1'b0, 4'd0, 1'b0, {name, "_release"});
  endtask

  task automatic doReset(input string name);
    asyncClear(name);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    probe      = 1'b0;
    CLR        = 1'b1;
    EN         = 1'b0;
    Din        = 1'b0;
    CNT_CLR    = 1'b0;
    #12;

    // Basic 1101 detection, then a 0 drops Det
    doReset("reset_basic");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "basic_e1");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "basic_e2");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "basic_e3");
    applyStimulus(1, 1, 0, 1, 4'd1, 0, "basic_e4_detect");
    applyStimulus(1, 0, 0, 0, 4'd1, 0, "basic_e5_drop");

    // Overlapping matches
    doReset("reset_overlap");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "ovl_e1");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "ovl_e2");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "ovl_e3");
    applyStimulus(1, 1, 0, 1, 4'd1, 0, "ovl_e4_detect");
    applyStimulus(1, 1, 0, 0, 4'd1, 0, "ovl_e5");
    applyStimulus(1, 0, 0, 0, 4'd1, 0, "ovl_e6");
    applyStimulus(1, 1, 0, 1, 4'd2, 0, "ovl_e7_detect");

    // Non-matches and a long run of ones
    doReset("reset_longrun");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "run_e1");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "run_e2");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "run_e3");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "run_e4");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "run_e5");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "run_e6");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "run_e7");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "run_e8");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "run_e9");
    applyStimulus(1, 1, 0, 1, 4'd1, 0, "run_e10_detect");

    // Stalls mid-pattern and while in S4
    doReset("reset_stall");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "stall_e1");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "stall_e2");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "stall_e3");
    applyStimulus(0, 1, 0, 0, 4'd0, 0, "stall_hold1");
    applyStimulus(0, 0, 0, 0, 4'd0, 0, "stall_hold2");
    applyStimulus(0, 1, 0, 0, 4'd0, 0, "stall_hold3");
    applyStimulus(1, 1, 0, 1, 4'd1, 0, "stall_detect");
    applyStimulus(0, 0, 0, 1, 4'd1, 0, "stall_s4_hold1");
    applyStimulus(0, 1, 0, 1, 4'd1, 0, "stall_s4_hold2");
    applyStimulus(1, 0, 0, 0, 4'd1, 0, "stall_release");

    // Sixteen detections wrap the counter and set Ovf
    doReset("reset_wrap");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "wrap_first_e1");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "wrap_first_e2");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "wrap_first_e3");
    applyStimulus(1, 1, 0, 1, 4'd1, 0, "wrap_first_detect");
    for (int k = 1; k < 16; k++) begin
      applyStimulus(1, 1, 0, 0, 4'(k), 0, $sformatf("wrap_%0d_a", k));
      applyStimulus(1, 0, 0, 0, 4'(k), 0, $sformatf("wrap_%0d_b", k));
      applyStimulus(1, 1, 0, 1, 4'((k + 1) % 16), (k == 15),
                    $sformatf("wrap_detect_%0d", k + 1));
    end
    applyStimulus(1, 1, 0, 0, 4'd0, 1, "wrap17_a");
    applyStimulus(1, 0, 0, 0, 4'd0, 1, "wrap17_b");
    applyStimulus(1, 1, 1, 1, 4'd0, 0, "wrap17_cntclr_priority");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "post_clr_a");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "post_clr_b");
    applyStimulus(1, 1, 0, 1, 4'd1, 0, "post_clr_detect");

    // Asynchronous clear while detecting and mid-pattern
    doReset("reset_async");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "async_e1");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "async_e2");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "async_e3");
    applyStimulus(1, 1, 0, 1, 4'd1, 0, "async_e4_detect");
    asyncClear("async_clr_in_s4");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "async_p1");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "async_p2");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "async_p3");
    asyncClear("async_clr_in_s3");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "async_no_detect");
    applyStimulus(1, 1, 0, 0, 4'd0, 0, "async_r2");
    applyStimulus(1, 0, 0, 0, 4'd0, 0, "async_r3");
    applyStimulus(1, 1, 0, 1, 4'd1, 0, "async_r4_detect");

    @(negedge Clk);
    EN = 1'b0;
    repeat (2) @(negedge Clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
